// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its IF/LSB requesters and the byte-wide RAM/IO port.
interface mem_arbiter_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_data;
  logic        lsb_req;
  logic        lsb_store;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic        mc_to_lsb_valid;
  logic        mc_to_lsb_ld_done;
  logic        mc_to_lsb_st_done;
  logic [31:0] mc_to_lsb_result;

  // Arbiter side: owns the RAM port and the response pulses.
  modport master (
    input  mem_din, io_buffer_full, if_req, if_addr,
           lsb_req, lsb_store, lsb_len, lsb_addr, lsb_data,
    output mem_dout, mem_a, mem_wr, mc_to_if_done, mc_to_if_data,
           mc_to_lsb_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_lsb_result
  );

  // Requester / memory side.
  modport slave (
    output mem_din, io_buffer_full, if_req, if_addr,
           lsb_req, lsb_store, lsb_len, lsb_addr, lsb_data,
    input  mem_dout, mem_a, mem_wr, mc_to_if_done, mc_to_if_data,
           mc_to_lsb_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_lsb_result
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the load/store
// buffer, splitting each multi-byte access into consecutive single-byte cycles.
module mem_arbiter #(
  parameter int unsigned IF_BYTES   = 4,
  parameter int unsigned IO_SEL_BIT = 17
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clr_in,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        valid_q, valid_d;
  logic        ld_done_q, ld_done_d;
  logic        st_done_q, st_done_d;
  logic [31:0] result_q, result_d;

  logic [2:0]  lsb_n;
  logic [31:0] cur_addr;
  logic [31:0] nxt_addr;
  logic [1:0]  rd_lane;
  logic [31:0] acc_upd;
  logic        resp_busy;

  function automatic logic is_io(input logic [31:0] a);
    return a[IO_SEL_BIT -: 2] == 2'b11;
  endfunction

  // Byte count of an LSB request; the illegal encoding 00 behaves as one byte.
  always_comb begin
    case (bus.lsb_len)
      2'b10:   lsb_n = 3'd2;
      2'b11:   lsb_n = 3'd4;
      default: lsb_n = 3'd1;
    endcase
  end

  assign cur_addr  = base_q + {29'd0, cnt_q};
  assign nxt_addr  = cur_addr + 32'd1;
  assign resp_busy = if_done_q | ld_done_q | st_done_q;
  // In the read states cnt counts edges since accept; the byte arriving now was
  // addressed two edges ago, so it lands in lane cnt-1.
  assign rd_lane   = cnt_q[1:0] - 2'd1;

  // Read accumulator with the byte currently on mem_din merged into its lane.
  always_comb begin
    acc_upd = acc_q;
    acc_upd[{rd_lane, 3'b000} +: 8] = bus.mem_din;
  end

  // Next-state, address sequencing and response generation.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    acc_d      = acc_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    valid_d    = 1'b0;
    ld_done_d  = 1'b0;
    st_done_d  = 1'b0;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (!clr_in && !resp_busy) begin
          if (bus.lsb_req) begin
            base_d  = bus.lsb_addr;
            len_d   = lsb_n;
            wdata_d = bus.lsb_data;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
            if (bus.lsb_store) begin
              state_d = LS_WRITE;
              // Byte 0 goes out on the accept edge unless the IO buffer blocks it.
              if (is_io(bus.lsb_addr) && bus.io_buffer_full) begin
                mem_a_d = '0;
              end else begin
                mem_a_d    = bus.lsb_addr;
                mem_dout_d = bus.lsb_data[7:0];
                mem_wr_d   = 1'b1;
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = LS_READ;
              mem_a_d = bus.lsb_addr;
            end
          end else if (bus.if_req) begin
            state_d = IF_READ;
            base_d  = bus.if_addr;
            len_d   = 3'(IF_BYTES);
            acc_d   = '0;
            cnt_d   = '0;
            mem_a_d = bus.if_addr;
          end
        end
      end
      IF_READ, LS_READ: begin
        if (clr_in) begin
          state_d = IDLE;
          mem_a_d = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          mem_a_d = (cnt_d < len_q) ? nxt_addr : '0;
          if (cnt_q != 3'd0) acc_d = acc_upd;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IF_READ) begin
              if_done_d = 1'b1;
              if_data_d = acc_upd;
            end else begin
              ld_done_d = 1'b1;
              result_d  = acc_upd;
            end
          end
        end
      end
      LS_WRITE: begin
        if (cnt_q == len_q) begin
          state_d   = IDLE;
          mem_a_d   = '0;
          cnt_d     = '0;
          st_done_d = 1'b1;
        end else if (is_io(cur_addr) && bus.io_buffer_full) begin
          mem_a_d = '0;
        end else begin
          mem_a_d    = cur_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      valid_q    <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      result_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      acc_q      <= acc_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      valid_q    <= valid_d;
      ld_done_q  <= ld_done_d;
      st_done_q  <= st_done_d;
      result_q   <= result_d;
    end
  end

  assign bus.mem_a             = mem_a_q;
  assign bus.mem_dout          = mem_dout_q;
  assign bus.mem_wr            = mem_wr_q;
  assign bus.mc_to_if_done     = if_done_q;
  assign bus.mc_to_if_data     = if_data_q;
  assign bus.mc_to_lsb_valid   = valid_q;
  assign bus.mc_to_lsb_ld_done = ld_done_q;
  assign bus.mc_to_lsb_st_done = st_done_q;
  assign bus.mc_to_lsb_result  = result_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO port; shares it between instruction fetch (IF) and the load/store buffer (LSB).
- Sequences each multi-byte transaction as consecutive single-byte RAM cycles.
- Returns word results raw and zero-extended. Sign extension stays with the LSB.
- Sits between the IF/LSB and the top-level RAM/IO bus.

Parameters:
IF_BYTES, 4, bytes per instruction fetch (1..4)
IO_SEL_BIT, 17, address bits [IO_SEL_BIT:IO_SEL_BIT-1]==2'b11 select the IO region

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low freezes all state
clr_in  in  1  pipeline flush (branch mispredict)
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1=write, 0=read
io_buffer_full  in  1  IO write buffer full
if_req  in  1  fetch request (level)
if_addr  in  32  fetch address
mc_to_if_done  out  1  one-cycle pulse, fetch data valid
mc_to_if_data  out  32  fetched bytes, little-endian
lsb_req  in  1  LSB request (level)
lsb_store  in  1  1=store, 0=load
lsb_len  in  2  01=1B, 10=2B, 11=4B; 00 illegal
lsb_addr  in  32  LSB address
lsb_data  in  32  store data (low bytes used)
mc_to_lsb_valid  out  1  one-cycle pulse, request accepted
mc_to_lsb_ld_done  out  1  one-cycle pulse, load result valid
mc_to_lsb_st_done  out  1  one-cycle pulse, store complete
mc_to_lsb_result  out  32  load bytes, little-endian, upper unused bytes 0

Behaviour:
- Reset (rst_n_in low, async): state IDLE, all outputs 0, byte counter 0, data accumulators 0.
- rdy_in low: every register holds, including outputs.
- States:
  - IDLE
  - IF_READ
  - LS_READ
  - LS_WRITE
- IDLE arbitration at each edge:
  - lsb_req has priority over if_req. An IF request is served at a later IDLE cycle.
  - Requests are ignored in any cycle where mc_to_if_done, mc_to_lsb_ld_done or mc_to_lsb_st_done is high. Requesters drop the request on that edge.
- Accept at edge E:
  - Latch base address, length N (IF: IF_BYTES; LSB: 1/2/4) and store data.
  - Set counter k=0.
  - For LSB, register mc_to_lsb_valid=1 for one cycle.
- Read:
  - Byte k: mem_a=base+k, mem_wr=0, registered at edge E+k.
  - mem_din is sampled at edge E+k+2 into result byte k.
  - The done pulse (mc_to_if_done or mc_to_lsb_ld_done) and the final data are registered at edge E+N+1, together with the return to IDLE.
  - LW latency: done visible 5 cycles after the accept edge.
  - mem_a is 0 once all addresses are issued.
- Write:
  - Byte k: mem_a=base+k, mem_dout=data[8k+7:8k], mem_wr=1, registered at edge E+k.
  - At edge E+N: mem_wr=0, mem_a=0, mc_to_lsb_st_done=1, return to IDLE.
- IO stall:
  - Applies in LS_WRITE when the target address is in the IO region and io_buffer_full=1.
  - That byte is not issued: mem_wr=0 and k is held until full drops.
  - Reads never stall.
- Address arithmetic is 32-bit and wraps modulo 2^32. Byte lanes for result/data are always k*8.
- clr_in (checked before arbitration):
  - IF_READ/LS_READ: abort. Return to IDLE, mem_a=0, no done pulse, partial data discarded.
  - LS_WRITE: ignored. A store has been committed and must complete, including its st_done pulse.
  - IDLE: no request accepted that edge.
  - Any pending mc_to_lsb_valid pulse still completes.
- Illegal lsb_len=00: treated as 1 byte.
- Async reset mid-transaction: immediate IDLE, mem_wr=0 without waiting for a clock.

Test Plan:
- LSB LW addr 0x100, RAM bytes 11,22,33,44 -> valid pulse 1 cycle after accept; mem_a 0x100..0x103 on consecutive cycles; ld_done 5 cycles after accept, result 0x44332211.
- LSB SB addr 0x30000, data 0xAB, io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 cycle mem_wr=1 with mem_dout=0xAB; st_done on the next cycle.
- if_req and lsb_req (LH 0x200) asserted together -> LSB served first, result 0x0000BBAA; IF fetch of 0x0 starts after ld_done; mc_to_if_done with the instruction word.
- IF fetch in progress, clr_in pulses after byte 1 -> no mc_to_if_done, IDLE next cycle, next request accepted normally.
- SW addr 0xFFFFFFFE data 0x01020304, clr_in mid-store -> bytes 04,03,02,01 written to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; st_done still pulses.
- rst_n_in dropped mid-write, asynchronously between clock edges -> mem_wr=0 immediately; after release, IDLE, all outputs 0.
